// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage
//
// Owns the program counter, presents it to a combinational instruction
// source, and buffers {pc, instr} pairs in a small FIFO for decode.
// Branch/jump redirects flush the buffer and reload the pc; misaligned or
// out-of-range fetch targets park the stage in FAULT until a good redirect.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   imem_addr      byte address to the instruction source (== fetch pc)
//   imem_instr     32-bit word returned combinationally for imem_addr
//   redirect_valid restart fetch at redirect_pc this cycle
//   redirect_pc    new fetch target
//   out_valid      FIFO head holds a valid entry
//   out_ready      decode accepts the head this cycle
//   out_pc         pc of the head entry
//   out_instr      instruction of the head entry
//   fetch_fault    high while in FAULT
//
// Handshake: a head entry transfers on any rising edge where
// out_valid && out_ready. out_valid never depends on out_ready, and the head
// (out_pc/out_instr) is stable while out_valid is high and not yet accepted,
// except that a redirect flushes the buffer and discards the head.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned IMEM_BYTES = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    // FIFO_DEPTH is a power of two, so pointers wrap naturally at PW bits.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [31:0]     pc_mem_q    [FIFO_DEPTH];
    logic [31:0]     pc_mem_d    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     instr_mem_d [FIFO_DEPTH];

    logic pop;
    logic push;
    logic fetch_legal;
    logic redirect_ok;

    // 33-bit compare so addr + 3 cannot wrap into a false pass near 2^32.
    function automatic logic addr_legal(input logic [31:0] addr);
        addr_legal = (({1'b0, addr} + 33'd3) < IMEM_LIMIT);
    endfunction

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        fetch_legal = addr_legal(fetch_pc_q);
        redirect_ok = (redirect_pc[1:0] == 2'b00) && addr_legal(redirect_pc);
        pop         = out_valid && out_ready;
        push        = (state_q == ST_RUN) && fetch_legal &&
                      ((count_q < DEPTH_C) || pop) && !redirect_valid;

        if (redirect_valid) begin
            // Flush wins over any same-cycle pop; the head is discarded.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            state_d    = redirect_ok ? ST_RUN : ST_FAULT;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_instr;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end else if ((state_q == ST_RUN) && !fetch_legal) begin
                // Sequential fetch ran off the end of memory; pc holds.
                state_d = ST_FAULT;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign out_valid   = (count_q != '0);
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign out_instr   = instr_mem_q[rd_ptr_q];
    assign fetch_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed bench for if_fetch with default parameters
// (RESET_PC = 0, FIFO_DEPTH = 2, IMEM_BYTES = 131072).
// The instruction source is a combinational function of imem_addr.
// Inputs change #1 after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;

    int n_checks;
    int n_errors;

    if_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- instruction source model ----
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0013;
            32'h0000_0004: mem_word = 32'h0010_0093;
            32'h0000_0008: mem_word = 32'h0020_0113;
            default:       mem_word = 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc"},    out_pc,             pc);
        check({tag, ".instr"}, out_instr,          mem_word(pc));
    endtask

    // ---- drivers ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        rst_n          = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        rst_n          = 1'b0;
        #2;

        // ---- reset values ----
        check("rst.valid", {31'd0, out_valid},   32'd0);
        check("rst.pc",    out_pc,               32'd0);
        check("rst.instr", out_instr,            32'd0);
        check("rst.fault", {31'd0, fetch_fault}, 32'd0);
        check("rst.addr",  imem_addr,            32'd0);

        // ---- streaming with out_ready high ----
        do_reset();
        out_ready = 1'b1;
        check("t1.addr0", imem_addr, 32'h0);
        step();
        check_head("t1.e1", 32'h0);
        check("t1.addr1", imem_addr, 32'h4);
        step();
        check_head("t1.e2", 32'h4);
        check("t1.addr2", imem_addr, 32'h8);
        step();
        check_head("t1.e3", 32'h8);
        check("t1.addr3", imem_addr, 32'hC);

        // ---- backpressure: saturate at 2, then drain with full throughput ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_head("t2.full", 32'h0);
        check("t2.stall_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        step();
        check_head("t2.d1", 32'h4);
        check("t2.d1_addr", imem_addr, 32'hC);
        step();
        check_head("t2.d2", 32'h8);
        step();
        check_head("t2.d3", 32'hC);

        // ---- redirect with FIFO full and a pop in the same cycle ----
        do_reset();
        out_ready = 1'b0;
        step();
        step();
        check_head("t3.full", 32'h0);
        out_ready = 1'b1;
        redirect(32'h100);
        check("t3.flush_valid", {31'd0, out_valid},   32'd0);
        check("t3.flush_addr",  imem_addr,            32'h100);
        check("t3.flush_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        check_head("t3.new1", 32'h100);
        step();
        check_head("t3.new2", 32'h104);

        // ---- misaligned redirect, then recovery ----
        redirect(32'h102);
        check("t4.fault",       {31'd0, fetch_fault}, 32'd1);
        check("t4.fault_valid", {31'd0, out_valid},   32'd0);
        check("t4.fault_addr",  imem_addr,            32'h102);
        step();
        check("t4.hold_fault",  {31'd0, fetch_fault}, 32'd1);
        check("t4.hold_valid",  {31'd0, out_valid},   32'd0);
        check("t4.hold_addr",   imem_addr,            32'h102);
        redirect(32'h200);
        check("t4.rec_fault",   {31'd0, fetch_fault}, 32'd0);
        check("t4.rec_valid",   {31'd0, out_valid},   32'd0);
        check("t4.rec_addr",    imem_addr,            32'h200);
        step();
        check_head("t4.rec_head", 32'h200);

        // ---- run off the end of memory ----
        redirect(32'h1_FFF8);
        check("t5.addr", imem_addr, 32'h1_FFF8);
        step();
        check_head("t5.e1", 32'h1_FFF8);
        step();
        check_head("t5.e2", 32'h1_FFFC);
        check("t5.end_addr",  imem_addr,            32'h2_0000);
        check("t5.end_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        check("t5.oob_fault", {31'd0, fetch_fault}, 32'd1);
        check("t5.oob_valid", {31'd0, out_valid},   32'd0);
        check("t5.oob_addr",  imem_addr,            32'h2_0000);
        step();
        check("t5.oob_hold",  {31'd0, out_valid},   32'd0);

        // ---- redirect to top of address space must not wrap into legal ----
        redirect(32'hFFFF_FFFC);
        check("t5.top_fault", {31'd0, fetch_fault}, 32'd1);
        redirect(32'h1_FFFC);
        check("t5.last_ok",   {31'd0, fetch_fault}, 32'd0);
        step();
        check_head("t5.last_head", 32'h1_FFFC);

        // ---- asynchronous reset mid-stream with 2 entries buffered ----
        out_ready = 1'b0;
        redirect(32'h300);
        step();
        step();
        check_head("t6.full", 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.valid", {31'd0, out_valid},   32'd0);
        check("t6.fault", {31'd0, fetch_fault}, 32'd0);
        check("t6.pc",    out_pc,               32'd0);
        check("t6.instr", out_instr,            32'd0);
        check("t6.addr",  imem_addr,            32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_head("t6.restart", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction source.
- Owns the program counter and drives the byte address into the instruction source. The source returns the 32-bit little-endian word combinationally in the same cycle.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (FIFO flush) and flags misaligned or out-of-range fetch targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2.
- IMEM_BYTES, 131072, instruction memory size in bytes; a fetch is legal iff addr + 3 < IMEM_BYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to the instruction source; always equals fetch_pc.
- imem_instr  in  32  word read combinationally at imem_addr.
- redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  pc of the head entry.
- out_instr  out  32  instruction of the head entry.
- fetch_fault  out  1  high while in FAULT (bad fetch target).

Behaviour:
- Reset values (async on rst_n low):
  - fetch_pc = RESET_PC, state = RUN, count = 0, rd/wr pointers = 0, all FIFO slots = 0.
  - Resulting outputs: out_valid = 0, out_pc = 0, out_instr = 0, fetch_fault = 0, imem_addr = RESET_PC.
  - If RESET_PC is illegal, state enters FAULT on the first edge after release.
- States: RUN, FAULT.
- pop = out_valid & out_ready.
- push = (state == RUN) & legal(fetch_pc) & (count < FIFO_DEPTH | pop) & ~redirect_valid.
- RUN, on each edge:
  - redirect_valid = 1:
    - Flush FIFO: count = 0, pointers = 0. Any pop that cycle is discarded.
    - fetch_pc <= redirect_pc. No push that cycle.
    - If redirect_pc[1:0] != 0, or redirect_pc is illegal, go to FAULT.
  - Otherwise, if push: write {fetch_pc, imem_instr} at wr pointer, fetch_pc <= fetch_pc + 4.
  - Otherwise, if fetch_pc is illegal: go to FAULT, fetch_pc holds.
  - Otherwise (full, no pop): stall, fetch_pc and imem_addr hold.
- FAULT:
  - No pushes. Decode may still drain existing entries.
  - fetch_fault = 1, fetch_pc holds.
  - A redirect to an aligned, legal target flushes the FIFO, loads fetch_pc and returns to RUN on the same edge.
  - A redirect to a bad target flushes the FIFO, loads fetch_pc and stays in FAULT.
- FIFO:
  - count updates +1 (push only), -1 (pop only), unchanged (both or neither). Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle are legal when full (full throughput). Pop when empty is impossible because out_valid = 0.
  - out_valid = (count != 0). out_pc/out_instr are driven from the rd-pointer slot. Popped and flushed slots keep stale data; consumers rely on out_valid.
- Latency and throughput:
  - Fetch-to-out_valid is 1 cycle.
  - Sustained 1 instr/cycle with out_ready held high.
  - Redirect-to-first-new-entry is 2 edges: one edge loads the pc, the next pushes.
- Arithmetic: fetch_pc + 4 is 32-bit, wrapping mod 2^32. 0xFFFF_FFFC is illegal for any IMEM_BYTES below 4 GiB, so the wrap is unreachable in RUN.
- Legality compare uses 33-bit arithmetic (addr + 3 must not overflow into a false pass).
- Reset mid-operation: everything returns to reset values immediately, asynchronously, regardless of state or FIFO contents.

Test Plan:
- Reset release, memory words 0x00000013 / 0x00100093 / 0x00200113 at 0/4/8, out_ready = 1 -> out_valid rises after edge 1; pairs (0, 0x00000013), (4, 0x00100093), (8, 0x00200113) on consecutive cycles; imem_addr steps 0, 4, 8, 12.
- out_ready = 0 for 5 cycles from reset -> count saturates at 2 (pc 0 and 4 held); imem_addr stalls at 8; releasing out_ready gives pc 0, 4, 8 with no gap or duplicate.
- FIFO full, out_ready = 1 and redirect_valid = 1 with redirect_pc = 0x100 in the same cycle -> next cycle out_valid = 0, imem_addr = 0x100; following cycle head = (0x100, mem[0x100]); no stale pc 0/4 emitted.
- Redirect to 0x102 -> fetch_fault = 1 next cycle, no further pushes; then redirect to 0x200 -> fetch_fault = 0 on that edge, head (0x200, mem[0x200]) one cycle later.
- Sequential fetch up to 0x1FFFC with IMEM_BYTES = 131072 -> entry 0x1FFFC delivered; fetch_pc = 0x20000 triggers FAULT; fetch_fault = 1 with no push of 0x20000.
- rst_n pulsed low mid-stream with 2 entries buffered -> out_valid, fetch_fault, out_pc and out_instr go to 0, and imem_addr goes to RESET_PC, immediately and without a clock edge.
